// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving two masters (m0 = CPU, m1 = loader or
// debug port) access to a single RAM port, with a bounded wait on RAM_ready.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mX_req/we/addr/wdata          master X request channel (held until mX_ready)
//   mX_ready, mX_rdata            master X completion pulse and read data
//   addr, ram_wdata, ram_we,      RAM-side command, held for the whole access
//   ram_en
//   data, RAM_ready               RAM read data and completion
//   grant                         master owning the current or last transaction
//   err                           one-cycle pulse when an access times out
module mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_en,
  input  logic [DW-1:0] data,
  input  logic          RAM_ready,
  output logic          grant,
  output logic          err
);

  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic [TW-1:0] r_timer;
  logic          r_ram_en;
  logic          r_ram_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_m0_ready;
  logic          r_m1_ready;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          r_grant;
  logic          r_err;

  logic          w_any;
  logic          w_pick;
  logic          w_timeout;
  logic [DW-1:0] w_rd;

  // Winner selection: a lone requester wins; on a tie the master not served last wins.
  assign w_any     = m0_req | m1_req;
  assign w_pick    = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_timeout = TO_EN && (r_timer == TO_LAST);
  // Aborted reads return zero.
  assign w_rd      = RAM_ready ? data : '0;

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_timer    <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_grant    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant  <= w_pick;
            r_addr   <= w_pick ? m1_addr  : m0_addr;
            r_wdata  <= w_pick ? m1_wdata : m0_wdata;
            r_ram_we <= w_pick ? m1_we    : m0_we;
            r_ram_en <= 1'b1;
            r_timer  <= '0;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_timer <= r_timer + TW'(1);
          // RAM_ready wins over a coincident timeout.
          if (RAM_ready || w_timeout) begin
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_err    <= ~RAM_ready;
            r_state  <= S_RESP;
            if (r_grant) begin
              r_m1_ready <= 1'b1;
              if (!r_ram_we) r_m1_rdata <= w_rd;
            end else begin
              r_m0_ready <= 1'b1;
              if (!r_ram_we) r_m0_rdata <= w_rd;
            end
          end
        end
        S_RESP: begin
          r_last  <= r_grant;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_ready  = r_m0_ready;
  assign m1_ready  = r_m1_ready;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign addr      = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_we    = r_ram_we;
  assign ram_en    = r_ram_en;
  assign grant     = r_grant;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small 16-word RAM model and
// programmable wait states (TIMEOUT = 4).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] addr, ram_wdata, data;
  logic        ram_we, ram_en, RAM_ready, grant, err;

  int errors = 0;
  int checks = 0;

  // RAM model controls
  logic [15:0] mem [16];
  int          ws_cfg;
  int          ws_cnt;
  logic        ram_stuck;

  mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .addr(addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_en(ram_en),
    .data(data), .RAM_ready(RAM_ready), .grant(grant), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents are loaded while reset is held across an edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
      mem[0] <= 16'h2100;
      mem[1] <= 16'hFF00;
      mem[3] <= 16'h00FF;
    end else if (ram_en && ram_we && RAM_ready) begin
      mem[addr[3:0]] <= ram_wdata;
    end
  end

  always @(posedge clk) begin
    if (rst || !ram_en) ws_cnt <= 0;
    else                ws_cnt <= ws_cnt + 1;
  end

  assign data      = mem[addr[3:0]];
  assign RAM_ready = !ram_stuck && (ws_cnt >= ws_cfg);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ram_en, ram_we, addr, ram_wdata, m0_ready, m1_ready, m0_rdata, m1_rdata, grant, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h rd0=%h rd1=%h g=%b err=%b, expected all zero",
               ram_en, ram_we, addr, m0_rdata, m1_rdata, grant, err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0003;
    tick();
    checks++;
    if ({ram_en, ram_we, addr} !== {1'b1, 1'b0, 16'h0003}) begin
      errors++;
      $display("FAIL single_access: got en=%b we=%b addr=%h, expected en=1 we=0 addr=0003", ram_en, ram_we, addr);
    end
    tick();
    checks++;
    if ({m0_ready, m1_ready, ram_en, m0_rdata, m1_rdata} !== {1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000}) begin
      errors++;
      $display("FAIL single_resp: got rdy0=%b rdy1=%b en=%b rd0=%h rd1=%h, expected 1 0 0 00ff 0000",
               m0_ready, m1_ready, ram_en, m0_rdata, m1_rdata);
    end
    m0_req = 1'b0;
    tick();
    checks++;
    if ({m0_ready, ram_en} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got rdy0=%b en=%b, expected 0 0", m0_ready, ram_en);
    end
  endtask

  task automatic test_write_read();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0004; m1_wdata = 16'h1120;
    tick();
    checks++;
    if ({ram_en, ram_we, addr, ram_wdata, grant} !== {1'b1, 1'b1, 16'h0004, 16'h1120, 1'b1}) begin
      errors++;
      $display("FAIL write_access: got en=%b we=%b addr=%h wd=%h g=%b, expected 1 1 0004 1120 1",
               ram_en, ram_we, addr, ram_wdata, grant);
    end
    tick();
    checks++;
    if ({m1_ready, m0_ready, err, ram_we, m1_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL write_resp: got rdy1=%b rdy0=%b err=%b we=%b rd1=%h, expected 1 0 0 0 0000",
               m1_ready, m0_ready, err, ram_we, m1_rdata);
    end
    m1_req = 1'b0;
    tick();
    m1_req = 1'b1; m1_we = 1'b0;
    tick();
    checks++;
    if ({ram_en, ram_we, addr, grant} !== {1'b1, 1'b0, 16'h0004, 1'b1}) begin
      errors++;
      $display("FAIL read_access: got en=%b we=%b addr=%h g=%b, expected 1 0 0004 1", ram_en, ram_we, addr, grant);
    end
    tick();
    checks++;
    if ({m1_ready, err, m1_rdata} !== {1'b1, 1'b0, 16'h1120}) begin
      errors++;
      $display("FAIL read_resp: got rdy1=%b err=%b rd1=%h, expected 1 0 1120", m1_ready, err, m1_rdata);
    end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic g;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0001;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 1);
      tick();
      checks++;
      if ({grant, ram_en, addr} !== {g, 1'b1, 16'(g)}) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got g=%b en=%b addr=%h, expected g=%b en=1 addr=%h",
                 k, grant, ram_en, addr, g, 16'(g));
      end
      tick();
      checks++;
      if ({m0_ready, m1_ready} !== (g ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL contention_ready[%0d]: got rdy0=%b rdy1=%b, expected winner %b only", k, m0_ready, m1_ready, g);
      end
      checks++;
      if ((g ? m1_rdata : m0_rdata) !== (g ? 16'hFF00 : 16'h2100)) begin
        errors++;
        $display("FAIL contention_rdata[%0d]: got rd0=%h rd1=%h, expected winner %b data %h",
                 k, m0_rdata, m1_rdata, g, (g ? 16'hFF00 : 16'h2100));
      end
      tick();
      checks++;
      if ({m0_ready, m1_ready, ram_en} !== 3'b000) begin
        errors++;
        $display("FAIL contention_idle[%0d]: got rdy0=%b rdy1=%b en=%b, expected 0 0 0", k, m0_ready, m1_ready, ram_en);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    ws_cfg = 3;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0005; m0_wdata = 16'hBEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if ({ram_en, ram_we, addr, ram_wdata, m0_ready} !== {1'b1, 1'b1, 16'h0005, 16'hBEEF, 1'b0}) begin
        errors++;
        $display("FAIL wait_access[%0d]: got en=%b we=%b addr=%h wd=%h rdy0=%b, expected 1 1 0005 beef 0",
                 c, ram_en, ram_we, addr, ram_wdata, m0_ready);
      end
    end
    tick();
    checks++;
    if ({m0_ready, err, ram_en} !== 3'b100) begin
      errors++;
      $display("FAIL wait_resp: got rdy0=%b err=%b en=%b, expected 1 0 0", m0_ready, err, ram_en);
    end
    m0_req = 1'b0;
    ws_cfg = 0;
    tick();
    m0_req = 1'b1; m0_we = 1'b0;
    tick();
    tick();
    checks++;
    if ({m0_ready, m0_rdata} !== {1'b1, 16'hBEEF}) begin
      errors++;
      $display("FAIL wait_readback: got rdy0=%b rd0=%h, expected 1 beef", m0_ready, m0_rdata);
    end
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    ram_stuck = 1'b1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0000;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if ({ram_en, err, m1_ready, grant} !== 4'b1001) begin
        errors++;
        $display("FAIL timeout_access[%0d]: got en=%b err=%b rdy1=%b g=%b, expected 1 0 0 1",
                 c, ram_en, err, m1_ready, grant);
      end
    end
    tick();
    checks++;
    if ({err, m1_ready, m0_ready, ram_en, m1_rdata} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL timeout_resp: got err=%b rdy1=%b rdy0=%b en=%b rd1=%h, expected 1 1 0 0 0000",
               err, m1_ready, m0_ready, ram_en, m1_rdata);
    end
    m1_req = 1'b0;
    tick();
    checks++;
    if ({err, m1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_after: got err=%b rdy1=%b, expected 0 0", err, m1_ready);
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0003;
    tick();
    tick();
    checks++;
    if ({ram_en, m0_ready, err} !== 3'b100) begin
      errors++;
      $display("FAIL recover_wait: got en=%b rdy0=%b err=%b, expected 1 0 0", ram_en, m0_ready, err);
    end
    ram_stuck = 1'b0;
    tick();
    checks++;
    if ({m0_ready, err, m0_rdata} !== {1'b1, 1'b0, 16'h00FF}) begin
      errors++;
      $display("FAIL recover_resp: got rdy0=%b err=%b rd0=%h, expected 1 0 00ff", m0_ready, err, m0_rdata);
    end
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ram_stuck = 1'b1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0001;
    tick();
    checks++;
    if ({ram_en, grant} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_access: got en=%b g=%b, expected 1 1", ram_en, grant);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({ram_en, ram_we, addr, ram_wdata, m0_ready, m1_ready, m0_rdata, m1_rdata, grant, err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got en=%b addr=%h rd0=%h rd1=%h g=%b err=%b, expected all zero",
               ram_en, addr, m0_rdata, m1_rdata, grant, err);
    end
    #1;
    rst = 1'b0;
    ram_stuck = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0000;
    tick();
    checks++;
    if ({grant, ram_en, addr} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL midreset_tie: got g=%b en=%b addr=%h, expected 0 1 0000", grant, ram_en, addr);
    end
    tick();
    checks++;
    if ({m0_ready, m1_ready, m0_rdata} !== {1'b1, 1'b0, 16'h2100}) begin
      errors++;
      $display("FAIL midreset_m0: got rdy0=%b rdy1=%b rd0=%h, expected 1 0 2100", m0_ready, m1_ready, m0_rdata);
    end
    m0_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({grant, ram_en, addr} !== {1'b1, 1'b1, 16'h0001}) begin
      errors++;
      $display("FAIL midreset_m1_grant: got g=%b en=%b addr=%h, expected 1 1 0001", grant, ram_en, addr);
    end
    tick();
    checks++;
    if ({m1_ready, err, m1_rdata} !== {1'b1, 1'b0, 16'hFF00}) begin
      errors++;
      $display("FAIL midreset_m1: got rdy1=%b err=%b rd1=%h, expected 1 0 ff00", m1_ready, err, m1_rdata);
    end
    m1_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    ws_cfg = 0;
    ram_stuck = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single 16-bit RAM port between the CPU (master 0) and a second requester such as a program loader or debug port (master 1). Each master issues one read or write at a time over a req/ready handshake. The arbiter grants round-robin, drives the RAM for the whole access, waits on `RAM_ready` with a bounded timeout, and returns read data to the winner. It sits between the masters and the RAM model or macro.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `TIMEOUT`, 15, maximum ACCESS cycles without `RAM_ready` before abort; range 0..255; 0 disables the timeout

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `m0_req`, `m1_req`  in  1  request; held high until `mX_ready`
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req is high
- `m0_addr`, `m1_addr`  in  AW  address; stable while req is high
- `m0_wdata`, `m1_wdata`  in  DW  write data; stable while req is high
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse
- `m0_rdata`, `m1_rdata`  out  DW  registered read data per master
- `addr`  out  AW  RAM address
- `ram_wdata`  out  DW  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_en`  out  1  RAM access strobe
- `data`  in  DW  RAM read data
- `RAM_ready`  in  1  RAM completion; may be tied to 1 for zero-wait RAM
- `grant`  out  1  index of the master owning the current or last transaction
- `err`  out  1  one-cycle pulse on timeout abort

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that master.
- IDLE, both requests: grant `!last`. `last` is the master served most recently; reset value 1, so master 0 wins the first tie.
- On grant:
  - Latch the winner's `addr`, `we` and `wdata` into RAM-side registers.
  - Set `grant`, clear the timer, go to ACCESS.
- ACCESS:
  - `ram_en` = 1 and `ram_we` = latched `we`.
  - `addr` and `ram_wdata` hold the latched values and stay constant for the whole state.
  - Timer increments each cycle.
- ACCESS with `RAM_ready` = 1: go to RESP.
  - Read: capture `data` into the winner's `rdata`.
  - Write: `rdata` unchanged.
- ACCESS with `RAM_ready` = 0, `TIMEOUT` != 0 and timer == `TIMEOUT` − 1 (the `TIMEOUT`-th ACCESS cycle): abort to RESP.
  - Pulse `err` in the RESP cycle.
  - Read abort: winner's `rdata` = 0.
  - Write abort: `rdata` unchanged.
- `RAM_ready` = 1 in the same cycle as the timeout condition: treated as success, no `err`.
- RESP:
  - `ram_en` = 0.
  - Winner's `ready` = 1 for exactly one cycle.
  - `last` = winner; go to IDLE.
- Masters sample `ready` at the edge and deassert or update `req` for the following cycle. `req` high in the IDLE cycle after `ready` is a new request.
- A non-granted master's `req` stays pending. Its `rdata` and `ready` are untouched.
- `grant` holds its value through IDLE until the next grant.

## Timing
- Reset values, applied immediately on `rst`:
  - Outputs: `ram_en`, `ram_we`, `addr`, `ram_wdata`, `m0_ready`, `m1_ready`, `m0_rdata`, `m1_rdata`, `grant`, `err` all = 0.
  - Internal: state = IDLE, `last` = 1, timer = 0.
- Cycle numbering: `req` is high in cycle 0 (sampled in IDLE).
  - `ram_en` is high in cycles 1..1+W, where W = number of cycles `RAM_ready` stays low.
  - `ready` pulses in cycle 2+W.
- Minimum latency is 2 cycles from `req` sampled to `ready`. Back-to-back throughput is one transaction per 3 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset mid-ACCESS or mid-RESP:
  - The transaction is dropped: no `ready`, no `err`, `rdata` cleared.
  - A master still requesting after reset release is re-arbitrated from IDLE.

## Test plan
1. Reset: assert `rst` asynchronously mid-cycle during an ACCESS → all outputs 0 before the next edge; after release, first tie goes to master 0.
2. Single read, `RAM_ready` tied 1, RAM word 3 = 0x00FF; m0 reads 0x0003 → `addr` = 0x0003 with `ram_en` in cycle 1; `m0_ready` pulses in cycle 2 with `m0_rdata` = 0x00FF; `m1_rdata` stays 0.
3. Write then read: m1 writes 0x1120 to 0x0004, then reads 0x0004 → `ram_we` = 1 only during the write ACCESS; `m1_rdata` = 0x1120; `err` never pulses.
4. Contention, RAM holds 0x2100, 0xFF00 at 0, 1: both masters hold `req` continuously, m0 reading 0x0000 and m1 reading 0x0001 → grant order 0, 1, 0, 1; `ready` pulses every 3 cycles alternating; `m0_rdata` = 0x2100, `m1_rdata` = 0xFF00.
5. Wait states: `RAM_ready` low for 3 ACCESS cycles → `ram_en`, `addr` and `ram_we` stable for 4 cycles; `ready` in cycle 5; no `err`.
6. Timeout, `TIMEOUT` = 4, `RAM_ready` held 0, m1 reads → 4 ACCESS cycles; then `err` and `m1_ready` pulse together with `m1_rdata` = 0x0000; a following m0 request completes normally once `RAM_ready` returns to 1.
